// File: rtl/beam_sum_pipe_if.sv
// -----------------------------------------------------------------------------
// beam_sum_pipe_if
// Bundles the beam adder data path and configuration handshake.
//   dat_i        : NCHAN*NSAMP*NBITS channel samples, channel c / sample k at
//                  [(c*NSAMP+k)*NBITS +: NBITS], sample 0 earliest
//   valid_i      : dat_i beat valid
//   cfg_wr_i     : write cfg_dly_i into the shadow delay of cfg_chan_i
//   cfg_chan_i   : shadow target channel (values >= NCHAN are ignored)
//   cfg_dly_i    : delay in samples (clamped to MAXDLY)
//   cfg_commit_i : copy all shadow delays to the active set
//   cfg_ack_o    : one-clock pulse, commit took effect
//   dat_o        : NSAMP*OUTBITS summed samples, sample k at [k*OUTBITS +: OUTBITS]
//   valid_o      : dat_o valid
// master = beat/config source, slave = beam_sum_pipe.
// -----------------------------------------------------------------------------
interface beam_sum_pipe_if #(
    parameter int NBITS  = 5,
    parameter int NSAMP  = 8,
    parameter int NCHAN  = 3,
    parameter int MAXDLY = 15
);
    localparam int DLYBITS  = $clog2(MAXDLY + 1);
    localparam int OUTBITS  = NBITS + $clog2(NCHAN);
    localparam int CHANBITS = $clog2(NCHAN);

    logic [NCHAN*NSAMP*NBITS-1:0] dat_i;
    logic                         valid_i;
    logic                         cfg_wr_i;
    logic [CHANBITS-1:0]          cfg_chan_i;
    logic [DLYBITS-1:0]           cfg_dly_i;
    logic                         cfg_commit_i;
    logic                         cfg_ack_o;
    logic [NSAMP*OUTBITS-1:0]     dat_o;
    logic                         valid_o;

    modport master (
        output dat_i, valid_i, cfg_wr_i, cfg_chan_i, cfg_dly_i, cfg_commit_i,
        input  cfg_ack_o, dat_o, valid_o
    );

    modport slave (
        input  dat_i, valid_i, cfg_wr_i, cfg_chan_i, cfg_dly_i, cfg_commit_i,
        output cfg_ack_o, dat_o, valid_o
    );
endinterface

// File: rtl/beam_sum_pipe.sv
// -----------------------------------------------------------------------------
// beam_sum_pipe
// Sums NCHAN unsigned channel streams (NSAMP samples per beat) after applying a
// per-channel programmable sample delay, forming a steered beam. Delays are
// written into shadow registers and committed together so every channel
// switches on the same beat.
// Ports:
//   clk_i   : sole clock
//   rst_n_i : synchronous active-low reset, clears all state
//   bus     : beam_sum_pipe_if.slave (beat input, config handshake, sum output)
// Latency: beat accepted at edge t appears on dat_o/valid_o after edge t+LAT.
// -----------------------------------------------------------------------------
module beam_sum_pipe #(
    parameter int NBITS  = 5,
    parameter int NSAMP  = 8,
    parameter int NCHAN  = 3,
    parameter int MAXDLY = 15
) (
    input logic             clk_i,
    input logic             rst_n_i,
    beam_sum_pipe_if.slave  bus
);
    localparam int DLYBITS  = $clog2(MAXDLY + 1);
    localparam int OUTBITS  = NBITS + $clog2(NCHAN);
    localparam int HIST     = (MAXDLY + NSAMP - 1) / NSAMP;
    localparam int LEVELS   = $clog2(NCHAN);
    localparam int LAT      = 2 + LEVELS;
    localparam int LEAVES   = 1 << LEVELS;
    localparam int WINLEN   = (HIST + 1) * NSAMP;
    localparam int WINBITS  = $clog2(WINLEN);
    localparam int FILLBITS = $clog2(HIST + 1);

    function automatic logic [DLYBITS-1:0] clampDly(input logic [DLYBITS-1:0] d);
        if (32'(d) > MAXDLY)
            return DLYBITS'(MAXDLY);
        return d;
    endfunction

    logic [DLYBITS-1:0]  shadowDly  [NCHAN];
    logic [DLYBITS-1:0]  shadowNext [NCHAN];
    logic [DLYBITS-1:0]  activeDly  [NCHAN];
    logic                ackReg;

    logic [NBITS-1:0]    datIn   [NCHAN][NSAMP];
    logic [NBITS-1:0]    dat_p0  [NCHAN][NSAMP];
    logic [DLYBITS-1:0]  dly_p0  [NCHAN];
    logic                vldIn_p0;
    logic [FILLBITS-1:0] fillCnt;
    logic [LAT:0]        vldPipe;

    logic [NBITS-1:0]    hist_p1 [NCHAN][HIST+1][NSAMP];
    logic [DLYBITS-1:0]  dly_p1  [NCHAN];

    logic [NBITS-1:0]    win     [NCHAN][WINLEN];
    logic [NBITS-1:0]    selComb [NCHAN][NSAMP];

    // Heap-ordered tree: node 1 is the root, leaves at LEAVES..2*LEAVES-1.
    // Leaves beyond NCHAN hold zero, which makes an odd operand a registered
    // pass-through.
    logic [OUTBITS-1:0]  node [1:2*LEAVES-1][NSAMP];

    // A write in the same cycle as a commit must be part of the committed set.
    always_comb begin
        shadowNext = shadowDly;
        if (bus.cfg_wr_i && (32'(bus.cfg_chan_i) < NCHAN))
            shadowNext[bus.cfg_chan_i] = clampDly(bus.cfg_dly_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                shadowDly[c] <= '0;
                activeDly[c] <= '0;
            end
            ackReg <= 1'b0;
        end else begin
            shadowDly <= shadowNext;
            if (bus.cfg_commit_i)
                activeDly <= shadowNext;
            ackReg <= bus.cfg_commit_i;
        end
    end

    always_comb begin
        datIn = '{default: '0};
        for (int c = 0; c < NCHAN; c++)
            for (int k = 0; k < NSAMP; k++)
                datIn[c][k] = bus.dat_i[(c*NSAMP+k)*NBITS +: NBITS];
    end

    // ---- stage p0: capture beat, the delay set it will use, and fill gating
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fillCnt  <= '0;
            vldIn_p0 <= 1'b0;
            vldPipe  <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                dly_p0[c] <= '0;
                for (int k = 0; k < NSAMP; k++)
                    dat_p0[c][k] <= '0;
            end
        end else begin
            vldIn_p0 <= bus.valid_i;
            vldPipe  <= {vldPipe[LAT-1:0], bus.valid_i && (fillCnt == FILLBITS'(HIST))};
            if (bus.valid_i && (fillCnt != FILLBITS'(HIST)))
                fillCnt <= fillCnt + FILLBITS'(1);
            dat_p0 <= datIn;
            dly_p0 <= activeDly;
        end
    end

    // ---- stage p1: history shift (index 0 = newest beat), stalls on invalid
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                dly_p1[c] <= '0;
                for (int h = 0; h <= HIST; h++)
                    for (int k = 0; k < NSAMP; k++)
                        hist_p1[c][h][k] <= '0;
            end
        end else begin
            dly_p1 <= dly_p0;
            if (vldIn_p0) begin
                for (int c = 0; c < NCHAN; c++) begin
                    for (int k = 0; k < NSAMP; k++)
                        hist_p1[c][0][k] <= dat_p0[c][k];
                    for (int h = 1; h <= HIST; h++)
                        for (int k = 0; k < NSAMP; k++)
                            hist_p1[c][h][k] <= hist_p1[c][h-1][k];
                end
            end
        end
    end

    // Flatten history oldest-first so sample k of the newest beat sits at
    // HIST*NSAMP+k; a delay d then simply indexes d positions earlier.
    always_comb begin
        win     = '{default: '0};
        selComb = '{default: '0};
        for (int c = 0; c < NCHAN; c++)
            for (int h = 0; h <= HIST; h++)
                for (int k = 0; k < NSAMP; k++)
                    win[c][(HIST-h)*NSAMP+k] = hist_p1[c][h][k];
        for (int c = 0; c < NCHAN; c++)
            for (int k = 0; k < NSAMP; k++)
                selComb[c][k] = win[c][WINBITS'(HIST*NSAMP+k) - WINBITS'(dly_p1[c])];
    end

    // ---- stage p2 (leaves) through p2+LEVELS (root): registered adder tree
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int n = 1; n < 2*LEAVES; n++)
                for (int k = 0; k < NSAMP; k++)
                    node[n][k] <= '0;
        end else begin
            for (int n = 1; n < LEAVES; n++)
                for (int k = 0; k < NSAMP; k++)
                    node[n][k] <= node[2*n][k] + node[2*n+1][k];
            for (int c = 0; c < NCHAN; c++)
                for (int k = 0; k < NSAMP; k++)
                    node[LEAVES+c][k] <= OUTBITS'(selComb[c][k]);
            for (int c = NCHAN; c < LEAVES; c++)
                for (int k = 0; k < NSAMP; k++)
                    node[LEAVES+c][k] <= '0;
        end
    end

    always_comb begin
        bus.dat_o = '0;
        for (int k = 0; k < NSAMP; k++)
            bus.dat_o[k*OUTBITS +: OUTBITS] = node[1][k];
    end

    assign bus.valid_o   = vldPipe[LAT];
    assign bus.cfg_ack_o = ackReg;

endmodule
